lr_car_sensor: RTL
==================

Name: lr_car_sensor

Overview:
- Local-road vehicle model and sensor that sits on the opposite side of the traffic light controller interface.
- Consumes the controller's hw_light/lr_light outputs and produces the lr_has_car input the controller samples.
- Keeps a queue of waiting local-road cars and releases them across the intersection only while lr_light is GREEN, with a reaction delay and a per-car crossing time.
- Flags illegal light combinations. Used as the closed-loop partner of the controller in system benches and on the board.

Parameters:
- QW, 4: width of the queue counter.
- QUEUE_MAX, 15: maximum number of queued cars; must be ≤ 2^QW-1.
- STARTUP, 2: reaction delay in cycles, from GREEN first sampled to the first car starting to cross; must be ≥ 1.
- PASS_CYCLES, 4: cycles one car occupies the intersection; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- car_arrive  in  1  one-cycle pulse; one car joins the queue.
- hw_light  in  3  highway light, one-hot: 001 RED, 010 YELLOW, 100 GREEN.
- lr_light  in  3  local-road light, same encoding.
- lr_has_car  out  1  high when queue_cnt != 0.
- queue_cnt  out  QW  cars waiting, including the car currently crossing.
- car_depart  out  1  one-cycle pulse in the last crossing cycle of a car.
- overflow  out  1  sticky; an arrival was dropped.
- light_error  out  1  sticky; an illegal light combination was sampled.

Behaviour:
- Reset: state IDLE, timer 0, queue_cnt 0, lr_has_car 0, car_depart 0, overflow 0, light_error 0. Reset mid-operation aborts any crossing without a depart pulse.
- lr_has_car is a pure decode of the queue_cnt register, with no added latency. car_depart is a decode of state/timer.
- Timer: internal counter, wide enough for max(STARTUP, PASS_CYCLES).
- green = (lr_light == 3'b100).

FSM (registered state and timer):
- IDLE: if green && queue_cnt != 0, go to REACT with timer=1. Otherwise stay.
- REACT:
  - If !green, go to IDLE (no car moves).
  - Else if timer == STARTUP, go to CROSS with timer=1.
  - Else timer++.
- CROSS: the car is committed and finishes even if the light changes.
  - While timer < PASS_CYCLES: timer++.
  - At timer == PASS_CYCLES: car_depart=1. Next state is CROSS with timer=1 if green && (queue after this edge) != 0; otherwise IDLE. There is no repeated reaction delay between back-to-back cars.
- Latency: GREEN sampled at edge E0 with cars waiting gives the first car_depart in the cycle following edge E(STARTUP+PASS_CYCLES-1). With defaults, car_depart is high between edges E5 and E6, and queue_cnt drops at E6. Later departs follow every PASS_CYCLES cycles.

Queue arithmetic (per edge, a=car_arrive, d=car_depart):
- a=1, d=0: if queue_cnt < QUEUE_MAX, increment; else hold and set overflow.
- a=0, d=1: decrement. The FSM guarantees queue_cnt ≥ 1 here.
- a=1, d=1: hold; no overflow, even when full.
- The count never wraps.

light_error: set at any edge where either light is not in {001, 010, 100}, or both lights are non-RED. It is never cleared except by rst. Light inputs are otherwise used as-is; an illegal value does not block crossing decisions.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, and they stay 0 with no arrivals and lights hw=100/lr=001.
- Arrivals under red: 3 car_arrive pulses, lr=001 -> queue_cnt=3, lr_has_car=1, no car_depart for 200 cycles.
- Release (defaults): 3 queued, lr set to 100 before edge E0 -> car_depart high in the cycles before E6, E10 and E14; queue_cnt reads 2, 1, 0; lr_has_car=0 after E14; state IDLE.
- Green drops during REACT: lr=100 sampled at E0 only, then 010 -> no car_depart, queue_cnt unchanged. Green drops during CROSS -> that car still departs, then the FSM idles with the remaining cars held.
- Full queue: 16 arrivals under red -> queue_cnt=15, overflow=1 and sticky. Under green, an arrival in the same cycle as car_depart -> queue_cnt unchanged, no new overflow.
- Light checking and mid-cycle reset: hw=100 with lr=100 for one cycle -> light_error=1 and it holds. lr=011 -> light_error=1. rst mid-CROSS -> no car_depart, queue_cnt=0, light_error=0.

Source files
------------

// File: rtl/lr_car_sensor.sv
// Local-road vehicle model: queues arriving cars, releases them across the
// intersection while the local-road light is GREEN, and flags illegal light pairs.
module lr_car_sensor #(
   parameter int QW          = 4,
   parameter int QUEUE_MAX   = 15,
   parameter int STARTUP     = 2,
   parameter int PASS_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          car_arrive,
   input  logic [2:0]    hw_light,
   input  logic [2:0]    lr_light,
   output logic          lr_has_car,
   output logic [QW-1:0] queue_cnt,
   output logic          car_depart,
   output logic          overflow,
   output logic          light_error
);

   localparam int TMAX = (STARTUP > PASS_CYCLES) ? STARTUP : PASS_CYCLES;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REACT = 2'd1,
      CROSS = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [QW-1:0] queue_q, queue_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;
   logic          green_s;
   logic          depart_s;

   function automatic logic legal_light(input logic [2:0] l);
      return (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
   endfunction

   assign green_s  = (lr_light == 3'b100);
   assign depart_s = (state_q == CROSS) && (timer_q == TW'(PASS_CYCLES));

   // Queue count with simultaneous arrive/depart cancelling; errors are sticky.
   always_comb begin
      queue_d = queue_q;
      ovf_d   = ovf_q;
      if (car_arrive && !depart_s) begin
         if (queue_q < QW'(QUEUE_MAX)) begin
            queue_d = queue_q + QW'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end else if (!car_arrive && depart_s) begin
         queue_d = queue_q - QW'(1);
      end else begin
         queue_d = queue_q;
      end
      err_d = err_q | ~legal_light(hw_light) | ~legal_light(lr_light)
            | ((hw_light != 3'b001) && (lr_light != 3'b001));
   end

   // A crossing car is committed; back-to-back cars skip the reaction delay.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (green_s && (queue_q != {QW{1'b0}})) begin
               state_d = REACT;
               timer_d = TW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         REACT: begin
            if (!green_s) begin
               state_d = IDLE;
               timer_d = {TW{1'b0}};
            end else if (timer_q == TW'(STARTUP)) begin
               state_d = CROSS;
               timer_d = TW'(1);
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         CROSS: begin
            if (timer_q < TW'(PASS_CYCLES)) begin
               timer_d = timer_q + TW'(1);
            end else if (green_s && (queue_d != {QW{1'b0}})) begin
               state_d = CROSS;
               timer_d = TW'(1);
            end else begin
               state_d = IDLE;
               timer_d = {TW{1'b0}};
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = {TW{1'b0}};
         end
      endcase
   end

   // State, timer, queue and sticky flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= {TW{1'b0}};
         queue_q <= {QW{1'b0}};
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         queue_q <= queue_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign queue_cnt   = queue_q;
   assign lr_has_car  = (queue_q != {QW{1'b0}});
   assign car_depart  = depart_s;
   assign overflow    = ovf_q;
   assign light_error = err_q;

endmodule
